// File: rtl/axis_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : axis_rr_arbiter_if
// Brief  : Four requester AXI-Stream slices plus the shared master stream.
// Rev    : 1.0  initial release
// ============================================================================
interface axis_rr_arbiter_if #(
    parameter int n = 4
);
    logic [3:0]       s_tvalid;
    logic [3:0]       s_tready;
    logic [4*8*n-1:0] s_tdata;
    logic [4*n-1:0]   s_tstrb;
    logic [4*n-1:0]   s_tkeep;
    logic [3:0]       s_tlast;

    logic             m_tvalid;
    logic             m_tready;
    logic [8*n-1:0]   m_tdata;
    logic [n-1:0]     m_tstrb;
    logic [n-1:0]     m_tkeep;
    logic             m_tlast;
    logic [1:0]       m_tdest;

    // The arbiter owns the master stream and the requester ready lines.
    modport master (
        input  s_tvalid, s_tdata, s_tstrb, s_tkeep, s_tlast, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tstrb, m_tkeep, m_tlast, m_tdest
    );

    modport slave (
        output s_tvalid, s_tdata, s_tstrb, s_tkeep, s_tlast, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tstrb, m_tkeep, m_tlast, m_tdest
    );
endinterface

`default_nettype wire

// File: rtl/axis_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : axis_rr_arbiter
// Brief  : Packet-granular round-robin arbiter, 4 AXI-Stream requesters -> 1.
// Rev    : 1.0  initial release
// ============================================================================
module axis_rr_arbiter #(
    parameter int n = 4
) (
    input  wire logic         aclk,
    input  wire logic         aresetn,
    axis_rr_arbiter_if.master axis,
    output logic              busy,
    output logic [15:0]       pkt_count
);
    localparam int c_dw = 8 * n;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      r_state;
    logic [1:0]  r_grant;
    logic [1:0]  r_ptr;
    logic [15:0] r_pkt_count;

    logic [1:0]  w_pick;
    logic        w_xfer;
    logic        w_last;

    // Scan from the highest offset down so the requester closest to r_ptr wins.
    always_comb begin
        w_pick = r_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (axis.s_tvalid[r_ptr + 2'(i)]) begin
                w_pick = r_ptr + 2'(i);
            end
        end
    end

    assign axis.m_tvalid = (r_state == GRANT) && axis.s_tvalid[r_grant];
    assign axis.s_tready = (r_state == GRANT) ? (4'(axis.m_tready) << r_grant) : 4'b0000;
    assign axis.m_tdata  = axis.s_tdata[r_grant * c_dw +: c_dw];
    assign axis.m_tstrb  = axis.s_tstrb[r_grant * n +: n];
    assign axis.m_tkeep  = axis.s_tkeep[r_grant * n +: n];
    assign axis.m_tlast  = axis.s_tlast[r_grant];
    assign axis.m_tdest  = r_grant;

    assign busy      = (r_state == GRANT);
    assign pkt_count = r_pkt_count;

    assign w_xfer = axis.m_tvalid && axis.m_tready;
    assign w_last = axis.s_tlast[r_grant];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= IDLE;
            r_grant     <= 2'd0;
            r_ptr       <= 2'd0;
            r_pkt_count <= 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|axis.s_tvalid) begin
                        r_grant <= w_pick;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    // Grant is held until the tail beat handshakes.
                    if (w_xfer && w_last) begin
                        r_state     <= IDLE;
                        r_ptr       <= r_grant + 2'd1;
                        r_pkt_count <= r_pkt_count + 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire
